// File: rtl/nec_ir_receiver.sv
// Purpose : NEC IR frame decoder; measures mark/space widths in microseconds and assembles the 32-bit frame word.
// Latency : an ir_in edge is seen 3 clk after the pin moves; ir_valid/ir_repeat/ir_error pulse 1 clk after the closing edge (or timeout).
// Backpr. : none; result pulses are single-cycle and must be sampled when they occur, ir_data holds until the next good frame.
//
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   ir_in        : raw demodulated IR (low = mark), asynchronous to clk
//   ir_data      : last good frame {inv cmd, cmd, inv addr, addr}
//   ir_valid     : 1-clk pulse when ir_data updates
//   ir_repeat    : 1-clk pulse on a valid repeat code
//   ir_error     : 1-clk pulse when a frame is aborted
//   ir_busy      : high whenever the decoder is not idle
module nec_ir_receiver #(
  parameter int TICKS_PER_US = 1,
  parameter bit CHECK_INV    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ir_in,
  output logic [31:0] ir_data,
  output logic        ir_valid,
  output logic        ir_repeat,
  output logic        ir_error,
  output logic        ir_busy
);

  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  // Window limits in microseconds, all inclusive.
  localparam logic [15:0] LDR_MARK_MIN  = 16'd8000;
  localparam logic [15:0] LDR_MARK_MAX  = 16'd10000;
  localparam logic [15:0] LDR_SPACE_MIN = 16'd4000;
  localparam logic [15:0] LDR_SPACE_MAX = 16'd5000;
  localparam logic [15:0] RPT_SPACE_MIN = 16'd1800;
  localparam logic [15:0] RPT_SPACE_MAX = 16'd2700;
  localparam logic [15:0] SHORT_MIN     = 16'd300;
  localparam logic [15:0] SHORT_MAX     = 16'd800;
  localparam logic [15:0] ONE_MIN       = 16'd1300;
  localparam logic [15:0] ONE_MAX       = 16'd2000;

  typedef enum logic [2:0] {
    IDLE,
    LDR_MARK,
    LDR_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_STOP
  } state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           sync3_q, sync3_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [31:0]    shreg_q, shreg_d;
  logic [4:0]     bit_idx_q, bit_idx_d;
  logic [31:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           repeat_q, repeat_d;
  logic           error_q, error_d;

  logic           us_tick;
  logic           mark_start;
  logic           mark_end;
  logic           abort;
  logic           bit_val;
  logic           bit_ok;

  function automatic logic in_win(input logic [15:0] v, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // sync3_q holds the previous synchronized level, so a 1->0 step is a mark start.
  assign mark_start = sync3_q & ~sync2_q;
  assign mark_end   = ~sync3_q & sync2_q;
  assign us_tick    = (presc_q == PW'(TICKS_PER_US - 1));

  always_comb begin
    sync1_d = ir_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    presc_d = us_tick ? '0 : presc_q + 1'b1;
    // Every edge restarts the width measurement; the FSM sees the pre-clear value.
    if (mark_start || mark_end) begin
      cnt_d = '0;
    end else if (us_tick && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    repeat_d  = 1'b0;
    error_d   = 1'b0;
    abort     = 1'b0;
    bit_val   = 1'b0;
    bit_ok    = 1'b0;

    // In every waiting state an edge is judged against its window first;
    // the timeout only fires when no edge arrives in that cycle.
    case (state_q)
      IDLE: begin
        if (mark_start) state_d = LDR_MARK;
      end
      LDR_MARK: begin
        if (mark_end) begin
          if (in_win(cnt_q, LDR_MARK_MIN, LDR_MARK_MAX)) state_d = LDR_SPACE;
          else abort = 1'b1;
        end else if (cnt_q > LDR_MARK_MAX) begin
          abort = 1'b1;
        end
      end
      LDR_SPACE: begin
        if (mark_start) begin
          if (in_win(cnt_q, LDR_SPACE_MIN, LDR_SPACE_MAX)) begin
            state_d   = BIT_MARK;
            bit_idx_d = '0;
          end else if (in_win(cnt_q, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
            state_d = RPT_STOP;
          end else begin
            abort = 1'b1;
          end
        end else if (cnt_q > LDR_SPACE_MAX) begin
          abort = 1'b1;
        end
      end
      BIT_MARK: begin
        if (mark_end) begin
          if (in_win(cnt_q, SHORT_MIN, SHORT_MAX)) state_d = BIT_SPACE;
          else abort = 1'b1;
        end else if (cnt_q > SHORT_MAX) begin
          abort = 1'b1;
        end
      end
      BIT_SPACE: begin
        if (mark_start) begin
          if (in_win(cnt_q, SHORT_MIN, SHORT_MAX)) begin
            bit_ok  = 1'b1;
            bit_val = 1'b0;
          end else if (in_win(cnt_q, ONE_MIN, ONE_MAX)) begin
            bit_ok  = 1'b1;
            bit_val = 1'b1;
          end else begin
            abort = 1'b1;
          end
          if (bit_ok) begin
            // NEC sends LSB first, so new bits enter at the top.
            shreg_d = {bit_val, shreg_q[31:1]};
            if (bit_idx_q == 5'd31) begin
              state_d = STOP_MARK;
            end else begin
              bit_idx_d = bit_idx_q + 5'd1;
              state_d   = BIT_MARK;
            end
          end
        end else if (cnt_q > ONE_MAX) begin
          abort = 1'b1;
        end
      end
      STOP_MARK: begin
        if (mark_end) begin
          if (!in_win(cnt_q, SHORT_MIN, SHORT_MAX)) begin
            abort = 1'b1;
          end else if (CHECK_INV && (shreg_q[23:16] != ~shreg_q[31:24])) begin
            abort = 1'b1;
          end else begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end else if (cnt_q > SHORT_MAX) begin
          abort = 1'b1;
        end
      end
      RPT_STOP: begin
        if (mark_end) begin
          if (in_win(cnt_q, SHORT_MIN, SHORT_MAX)) begin
            repeat_d = 1'b1;
            state_d  = IDLE;
          end else begin
            abort = 1'b1;
          end
        end else if (cnt_q > SHORT_MAX) begin
          abort = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A partial frame is dropped entirely; ir_data keeps the last good word.
    if (abort) begin
      error_d   = 1'b1;
      state_d   = IDLE;
      shreg_d   = '0;
      bit_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      sync3_q   <= 1'b1;
      presc_q   <= '0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      repeat_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      repeat_q  <= repeat_d;
      error_q   <= error_d;
    end
  end

  assign ir_data   = data_q;
  assign ir_valid  = valid_q;
  assign ir_repeat = repeat_q;
  assign ir_error  = error_q;
  assign ir_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Purpose : self-checking bench for nec_ir_receiver; several independent decoders run side by side.
// Latency : result events are matched against a per-lane scoreboard as they appear.
// Backpr. : none; stimulus durations are fixed, so the run always ends on its own.
//
// Lane 0: good frame then repeat.   Lanes 1/2 (CHECK_INV 1/0) share one line: bad inverse byte, short leader.
// Lane 3: bit-space timeout then recovery frame.  Lane 4: reset mid-frame then frame.
// Lane 5: table of leader/repeat window boundary vectors.
// With TICKS_PER_US=1 and pin changes on the falling clock edge, a level held for D us
// reaches the decoder as a count of D-1 at the closing edge.
`timescale 1ns/1ps
module tb_nec_ir_receiver;

  localparam int NL = 6;
  localparam logic [2:0] K_VAL = 3'b001;
  localparam logic [2:0] K_RPT = 3'b010;
  localparam logic [2:0] K_ERR = 3'b100;

  logic          clk = 1'b0;
  logic [NL-1:0] ir_l;
  logic [NL-1:0] rst_n;
  logic [NL-1:0] val, rep, err, busy;
  logic [31:0]   data [NL];

  always #500 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    nec_ir_receiver #(
      .TICKS_PER_US(1),
      .CHECK_INV   ((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk      (clk),
      .reset_n  (rst_n[g]),
      .ir_in    (ir_l[g]),
      .ir_data  (data[g]),
      .ir_valid (val[g]),
      .ir_repeat(rep[g]),
      .ir_error (err[g]),
      .ir_busy  (busy[g])
    );
  end

  typedef struct {
    int          lane;
    logic [2:0]  kind;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          lm;    // leader mark us
    int          ls;    // leader space us, 0 = stop after the mark
    int          sm;    // stop mark us
    logic [2:0]  kind;  // expected event
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];
  int   n_vec = 0;
  int   n_err = 0;
  bit   done  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int l, input logic [2:0] k, input logic [31:0] d);
    exp_t e;
    e.lane = l;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drive(input int l, input logic lvl, input int us);
    ir_l[l] = lvl;
    if (l == 1) ir_l[2] = lvl;
    repeat (us) @(negedge clk);
  endtask

  task automatic send_bits(input int l, input logic [31:0] w, input int n, input bit fast);
    for (int i = 0; i < n; i++) begin
      drive(l, 1'b0, fast ? 320 : 562);
      drive(l, 1'b1, w[i] ? (fast ? 1320 : 1687) : (fast ? 320 : 562));
    end
  endtask

  task automatic send_frame(input int l, input logic [31:0] w, input bit fast);
    drive(l, 1'b0, fast ? 8050 : 9000);
    drive(l, 1'b1, fast ? 4050 : 4500);
    send_bits(l, w, 32, fast);
    drive(l, 1'b0, fast ? 320 : 562);
    drive(l, 1'b1, 200);
  endtask

  task automatic check_events();
    for (int l = 0; l < NL; l++) begin
      if ({err[l], rep[l], val[l]} != 3'b000) begin
        int idx;
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (idx < 0 && sb[k].lane == l) idx = k;
        if (idx < 0) begin
          n_vec++;
          n_err++;
          $display("FAIL lane%0d unexpected event: got kind %b data %h, required no event",
                   l, {err[l], rep[l], val[l]}, data[l]);
        end else begin
          chk($sformatf("lane%0d kind", l), {29'b0, err[l], rep[l], val[l]},
              {29'b0, sb[idx].kind});
          chk($sformatf("lane%0d data", l), data[l], sb[idx].data);
          sb.delete(idx);
        end
      end
    end
  endtask

  task automatic lane_a();
    expect_ev(0, K_VAL, 32'hBA45_FF00);
    send_frame(0, 32'hBA45_FF00, 1'b0);
    expect_ev(0, K_RPT, 32'hBA45_FF00);
    drive(0, 1'b0, 9000);
    drive(0, 1'b1, 2250);
    drive(0, 1'b0, 562);
    drive(0, 1'b1, 200);
  endtask

  task automatic lane_b();
    expect_ev(1, K_ERR, 32'h0);
    expect_ev(2, K_VAL, 32'hBB45_FF00);
    send_frame(1, 32'hBB45_FF00, 1'b0);
    // 7000 us leader mark: rejected at its closing edge.
    expect_ev(1, K_ERR, 32'h0);
    expect_ev(2, K_ERR, 32'hBB45_FF00);
    drive(1, 1'b0, 7000);
    drive(1, 1'b1, 2);
    chk("short leader busy1 before", {31'b0, busy[1]}, 32'd1);
    chk("short leader busy2 before", {31'b0, busy[2]}, 32'd1);
    @(negedge clk);
    chk("short leader err1", {31'b0, err[1]}, 32'd1);
    chk("short leader busy1 after", {31'b0, busy[1]}, 32'd0);
    chk("short leader busy2 after", {31'b0, busy[2]}, 32'd0);
    drive(1, 1'b1, 200);
  endtask

  task automatic lane_d();
    expect_ev(3, K_ERR, 32'h0);
    drive(3, 1'b0, 9000);
    drive(3, 1'b1, 4500);
    send_bits(3, 32'hBA45_FF00, 10, 1'b0);
    drive(3, 1'b0, 562);
    // Space after bit 10's mark: count passes 2000 on the 2004th falling edge,
    // the error pulse follows one clk later.
    drive(3, 1'b1, 2004);
    chk("timeout err at cnt 2000", {31'b0, err[3]}, 32'd0);
    @(negedge clk);
    chk("timeout err at cnt 2001", {31'b0, err[3]}, 32'd1);
    chk("timeout busy", {31'b0, busy[3]}, 32'd0);
    drive(3, 1'b1, 200);
    expect_ev(3, K_VAL, 32'hDD22_EF10);
    send_frame(3, 32'hDD22_EF10, 1'b1);
  endtask

  task automatic lane_e();
    expect_ev(4, K_VAL, 32'h7E81_0012);
    drive(4, 1'b0, 8050);
    drive(4, 1'b1, 4050);
    send_bits(4, 32'hFF00_0000, 20, 1'b1);
    drive(4, 1'b0, 100);
    chk("mid-frame busy", {31'b0, busy[4]}, 32'd1);
    rst_n[4] = 1'b0;
    #1;
    chk("reset data",   data[4], 32'h0);
    chk("reset valid",  {31'b0, val[4]},  32'd0);
    chk("reset repeat", {31'b0, rep[4]},  32'd0);
    chk("reset error",  {31'b0, err[4]},  32'd0);
    chk("reset busy",   {31'b0, busy[4]}, 32'd0);
    ir_l[4] = 1'b1;
    repeat (50) @(negedge clk);
    rst_n[4] = 1'b1;
    drive(4, 1'b1, 50);
    send_frame(4, 32'h7E81_0012, 1'b1);
  endtask

  task automatic lane_f();
    for (int v = 0; v < 7; v++) begin
      expect_ev(5, vt[v].kind, 32'h0);
      drive(5, 1'b0, vt[v].lm);
      if (vt[v].ls > 0) begin
        drive(5, 1'b1, vt[v].ls);
        drive(5, 1'b0, vt[v].sm);
      end
      drive(5, 1'b1, 300);
    end
  endtask

  initial begin
    vt[0] = '{lm: 8001,  ls: 2250, sm: 562, kind: K_RPT};  // leader count 8000
    vt[1] = '{lm: 8000,  ls: 0,    sm: 0,   kind: K_ERR};  // leader count 7999
    vt[2] = '{lm: 10001, ls: 2250, sm: 562, kind: K_RPT};  // leader count 10000
    vt[3] = '{lm: 10002, ls: 0,    sm: 0,   kind: K_ERR};  // leader count 10001
    vt[4] = '{lm: 8050,  ls: 1801, sm: 801, kind: K_RPT};  // space 1800, stop 800
    vt[5] = '{lm: 8050,  ls: 2702, sm: 562, kind: K_ERR};  // space 2701
    vt[6] = '{lm: 8050,  ls: 2250, sm: 300, kind: K_ERR};  // stop 299

    ir_l  = '1;
    rst_n = '0;
    repeat (5) @(negedge clk);
    for (int g = 0; g < NL; g++) begin
      chk($sformatf("rst%0d data", g),   data[g], 32'h0);
      chk($sformatf("rst%0d valid", g),  {31'b0, val[g]},  32'd0);
      chk($sformatf("rst%0d repeat", g), {31'b0, rep[g]},  32'd0);
      chk($sformatf("rst%0d error", g),  {31'b0, err[g]},  32'd0);
      chk($sformatf("rst%0d busy", g),   {31'b0, busy[g]}, 32'd0);
    end
    rst_n = '1;
    repeat (5) @(negedge clk);

    fork
      begin
        fork
          lane_a();
          lane_b();
          lane_d();
          lane_e();
          lane_f();
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          check_events();
        end
      end
    join

    while (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL lane%0d missing event: got none, required kind %b data %h",
               sb[0].lane, sb[0].kind, sb[0].data);
      sb.delete(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
